// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [XLEN_DEFAULT-1:0] ZERO_WORD = '0;
  localparam logic RST_ACTIVE = 1'b0;
  localparam int unsigned REG0_ADDR = 0;

endpackage

// File: rtl/regfile_sb_rf_read_port.sv
// One combinational read port: register array lookup with write bypass and operand readiness.
module rf_read_port
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned NREG = 32,
  parameter int unsigned NWR  = 2,
  parameter int unsigned AW   = 5
) (
  input  logic                re,
  input  logic [AW-1:0]       raddr,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NWR-1:0]      wclr,
  input  logic [NREG*XLEN-1:0] regs,
  input  logic [NREG-1:0]     busy,
  output logic [XLEN-1:0]     rdata,
  output logic                rready
);

  // Stored value or bypassed write data; ascending scan lets the highest write port win.
  always_comb begin
    rdata  = '0;
    rready = 1'b0;
    if (re) begin
      if (raddr == AW'(REG0_ADDR)) begin
        rready = 1'b1;
      end else begin
        rdata  = regs[int'(raddr)*XLEN +: XLEN];
        rready = ~busy[raddr];
        for (int j = 0; j < int'(NWR); j++) begin
          if (we[j] && (waddr[j*AW +: AW] == raddr)) begin
            rdata = wdata[j*XLEN +: XLEN];
            // Only a retiring write resolves the hazard; a plain bypass does not.
            if (wclr[j]) rready = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write bypass and per-register busy scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 2,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      re,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rready,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NWR-1:0]      wclr,
  input  logic                claim,
  input  logic [AW-1:0]       claim_addr,
  input  logic                flush,
  output logic [NREG-1:0]     busy,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0]      mem_q [NREG];
  logic [NREG*XLEN-1:0] regs_flat;
  logic [NREG-1:0]      busy_q, busy_d, clr_vec;
  logic [AW:0]          cnt_q, cnt_d;
  logic                 rst_off;

  assign rst_off = (rst != RST_ACTIVE);

  // Register storage; highest enabled port wins on an address collision, x0 never written.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      for (int r = 0; r < int'(NREG); r++) mem_q[r] <= '0;
    end else begin
      for (int j = 0; j < int'(NWR); j++) begin
        if (we[j] && (waddr[j*AW +: AW] != AW'(REG0_ADDR))) begin
          mem_q[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Flatten storage for the read ports.
  always_comb begin
    regs_flat = '0;
    for (int r = 0; r < int'(NREG); r++) regs_flat[r*XLEN +: XLEN] = mem_q[r];
  end

  // Registers retired by this cycle's writes.
  always_comb begin
    clr_vec = '0;
    for (int j = 0; j < int'(NWR); j++) begin
      if (we[j] && wclr[j]) clr_vec[waddr[j*AW +: AW]] = 1'b1;
    end
  end

  // Scoreboard next state: flush, then claim, then clear; popcount of the result.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = '0;
    for (int r = 1; r < int'(NREG); r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (claim && (claim_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (clr_vec[r]) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
    for (int r = 0; r < int'(NREG); r++) cnt_d = cnt_d + (AW+1)'(busy_d[r]);
  end

  // Scoreboard and its count update together so they always agree.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

  for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
    // Gating the enable keeps reads silent while reset is held.
    rf_read_port #(
      .XLEN (XLEN),
      .NREG (NREG),
      .NWR  (NWR),
      .AW   (AW)
    ) u_rd (
      .re     (re[i] & rst_off),
      .raddr  (raddr[i*AW +: AW]),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .wclr   (wclr),
      .regs   (regs_flat),
      .busy   (busy_q),
      .rdata  (rdata[i*XLEN +: XLEN]),
      .rready (rready[i])
    );
  end

endmodule
